// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one bit per clock.
// Define BIN2BCD_SIGNED_EN to treat bin as two's complement and report the sign on neg.
module bin2bcd_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_WIDTH-1:0]  bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg
);

  localparam int CNT_W      = $clog2(BIN_WIDTH + 1);
  // ceil(BIN_WIDTH * log10(2)) in integer arithmetic
  localparam int MIN_DIGITS = (BIN_WIDTH * 30103 + 99999) / 100000;

  generate
    if (BIN_WIDTH < 2 || DIGITS < MIN_DIGITS) begin : g_param_check
      $error("bin2bcd_seq: BIN_WIDTH must be >= 2 and DIGITS >= ceil(BIN_WIDTH*log10(2))");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t                 r_state;
  logic [BIN_WIDTH-1:0]   r_sr;
  logic [4*DIGITS-1:0]    r_wk;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_busy;
  logic                   r_done;
  logic [4*DIGITS-1:0]    r_bcd;

  logic [BIN_WIDTH-1:0]   w_operand;
  logic [BIN_WIDTH-1:0]   w_sr_next;
  logic [4*DIGITS-1:0]    w_wk_next;

  // Out-of-range digits (10-15) pass through unchanged.
  function automatic logic [3:0] digit_adjust(input logic [3:0] d);
    if (d >= 4'd5 && d <= 4'd9) begin
      return d + 4'd3;
    end
    return d;
  endfunction

  // Adjust and shift fused: the top digit only keeps its low three adjusted bits.
  always_comb begin
    w_wk_next    = '0;
    w_wk_next[0] = r_sr[BIN_WIDTH-1];
    for (int d = 0; d < DIGITS - 1; d++) begin
      w_wk_next[4*d+1 +: 4] = digit_adjust(r_wk[4*d +: 4]);
    end
    w_wk_next[4*DIGITS-3 +: 3] = 3'(digit_adjust(r_wk[4*DIGITS-4 +: 4]));
  end

  assign w_sr_next = {r_sr[BIN_WIDTH-2:0], 1'b0};

`ifdef BIN2BCD_SIGNED_EN
  logic r_sign;
  logic r_neg;
  logic w_is_neg;

  assign w_is_neg  = bin[BIN_WIDTH-1];
  assign w_operand = w_is_neg ? (BIN_WIDTH'(0) - bin) : bin;
  assign neg       = r_neg;
`else
  assign w_operand = bin;
  assign neg       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_sr    <= '0;
      r_wk    <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_bcd   <= '0;
`ifdef BIN2BCD_SIGNED_EN
      r_sign  <= 1'b0;
      r_neg   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SHIFT;
            r_sr    <= w_operand;
            r_wk    <= '0;
            r_cnt   <= CNT_W'(BIN_WIDTH);
            r_busy  <= 1'b1;
`ifdef BIN2BCD_SIGNED_EN
            r_sign  <= w_is_neg;
`endif
          end
        end
        S_SHIFT: begin
          r_sr  <= w_sr_next;
          r_wk  <= w_wk_next;
          r_cnt <= r_cnt - CNT_W'(1);
          // Result register loads on the last shift so it is visible with done.
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_bcd   <= w_wk_next;
`ifdef BIN2BCD_SIGNED_EN
            r_neg   <= r_sign;
`endif
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule
